// File: rtl/fifo_pkg.sv
// Shared constants and flag bundle for the byte-to-halfword FIFO.
package fifo_pkg;

  localparam int unsigned WrDepthW = 14;
  localparam int unsigned RdDepthW = WrDepthW - 1;
  localparam int unsigned WrDataW  = 8;
  localparam int unsigned Ratio    = 2;
  localparam int unsigned RdDataW  = Ratio * WrDataW;
  localparam int unsigned WrDepth  = 2 ** WrDepthW;
  localparam int unsigned RdDepth  = 2 ** RdDepthW;

  localparam int unsigned AlmostFullDefault  = 1020;
  localparam int unsigned AlmostEmptyDefault = 4;

  typedef struct packed {
    logic full;
    logic afull;
    logic empty;
    logic aempty;
  } fifo_flags_t;

endpackage

// File: rtl/byte_to_word_fifo_if.sv
// Write/read handshake and status bundle of the byte-to-halfword FIFO.
interface byte_to_word_fifo_if
  import fifo_pkg::*;
#(
  parameter int unsigned WR_DEPTH_WIDTH = WrDepthW,
  parameter int unsigned RD_DEPTH_WIDTH = RdDepthW,
  parameter int unsigned WR_DATA_WIDTH  = WrDataW,
  parameter int unsigned RD_DATA_WIDTH  = RdDataW
);

  logic [WR_DATA_WIDTH-1:0]  wr_data;
  logic                      wr_en;
  logic                      wr_full;
  logic [WR_DEPTH_WIDTH:0]   wr_water_level;
  logic                      almost_full;
  logic                      rd_en;
  logic [RD_DATA_WIDTH-1:0]  rd_data;
  logic                      rd_empty;
  logic [RD_DEPTH_WIDTH:0]   rd_water_level;
  logic                      almost_empty;

  modport master (
    output wr_data, wr_en, rd_en,
    input  wr_full, wr_water_level, almost_full, rd_data, rd_empty, rd_water_level, almost_empty
  );

  modport slave (
    input  wr_data, wr_en, rd_en,
    output wr_full, wr_water_level, almost_full, rd_data, rd_empty, rd_water_level, almost_empty
  );

endinterface

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM with per-byte write enables and a registered, resettable read port.
module fifo_sdp_ram #(
  parameter int unsigned AddrWidth = 13,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Bytes     = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           wr_en_i,
  input  logic [Bytes-1:0]               wr_be_i,
  input  logic [AddrWidth-1:0]           wr_addr_i,
  input  logic [Bytes*ByteWidth-1:0]     wr_data_i,
  input  logic                           rd_en_i,
  input  logic [AddrWidth-1:0]           rd_addr_i,
  output logic [Bytes*ByteWidth-1:0]     rd_data_o
);

  localparam int unsigned Depth = 2 ** AddrWidth;

  logic [Bytes*ByteWidth-1:0] mem [Depth];
  logic [Bytes*ByteWidth-1:0] rd_data_d, rd_data_q;

  // Storage array carries no reset so it can map onto block RAM.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < Bytes; b++) begin
      if (wr_en_i && wr_be_i[b]) begin
        mem[wr_addr_i][b*ByteWidth +: ByteWidth] <= wr_data_i[b*ByteWidth +: ByteWidth];
      end
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      rd_data_d = mem[rd_addr_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/byte_to_word_fifo.sv
// Single-clock FIFO, 8-bit writes packed LSB-first into 16-bit reads, with level and almost flags.
module byte_to_word_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WR_DEPTH_WIDTH   = WrDepthW,
  parameter int unsigned WR_DATA_WIDTH    = WrDataW,
  parameter int unsigned RD_DEPTH_WIDTH   = RdDepthW,
  parameter int unsigned RD_DATA_WIDTH    = RdDataW,
  parameter int unsigned ALMOST_FULL_NUM  = AlmostFullDefault,
  parameter int unsigned ALMOST_EMPTY_NUM = AlmostEmptyDefault
) (
  input logic                clk,
  input logic                rst_n,
  byte_to_word_fifo_if.slave bus
);

  localparam int unsigned CntW = WR_DEPTH_WIDTH + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(2 ** WR_DEPTH_WIDTH);

  logic [WR_DEPTH_WIDTH-1:0] wr_ptr_d, wr_ptr_q;
  logic [RD_DEPTH_WIDTH-1:0] rd_ptr_d, rd_ptr_q;
  logic [CntW-1:0]           count_d, count_q;
  fifo_flags_t               flags_d, flags_q;

  logic                     wr_accept, rd_accept;
  logic [Ratio-1:0]         wr_be;
  logic [RD_DATA_WIDTH-1:0] rd_data;

  // Acceptance uses the registered flags, so a same-cycle read never unblocks a full write.
  assign wr_accept = bus.wr_en & ~flags_q.full;
  assign rd_accept = bus.rd_en & ~flags_q.empty;
  assign wr_be     = {wr_ptr_q[0], ~wr_ptr_q[0]};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + WR_DEPTH_WIDTH'(1);
      count_d  = count_d + CntW'(1);
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + RD_DEPTH_WIDTH'(1);
      count_d  = count_d - CntW'(2);
    end
    flags_d.full   = (count_d == FullCount);
    flags_d.afull  = (count_d >= CntW'(ALMOST_FULL_NUM));
    flags_d.empty  = (count_d < CntW'(2));
    flags_d.aempty = (count_d[CntW-1:1] <= (CntW-1)'(ALMOST_EMPTY_NUM));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flags_q  <= '{full: 1'b0, afull: 1'b0, empty: 1'b1, aempty: 1'b1};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
    end
  end

  fifo_sdp_ram #(
    .AddrWidth (RD_DEPTH_WIDTH),
    .ByteWidth (WR_DATA_WIDTH),
    .Bytes     (Ratio)
  ) u_ram (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wr_en_i   (wr_accept),
    .wr_be_i   (wr_be),
    .wr_addr_i (wr_ptr_q[WR_DEPTH_WIDTH-1:1]),
    .wr_data_i ({Ratio{bus.wr_data}}),
    .rd_en_i   (rd_accept),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  assign bus.rd_data        = rd_data;
  assign bus.wr_full        = flags_q.full;
  assign bus.almost_full    = flags_q.afull;
  assign bus.rd_empty       = flags_q.empty;
  assign bus.almost_empty   = flags_q.aempty;
  assign bus.wr_water_level = count_q;
  assign bus.rd_water_level = count_q[CntW-1:1];

endmodule

// File: tb/tb_byte_to_word_fifo.sv
// Directed bench for byte_to_word_fifo: fill/drain, odd-byte and simultaneous vectors, async reset.
module tb_byte_to_word_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  byte_to_word_fifo_if bus ();

  byte_to_word_fifo dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        rd_en;
    logic [14:0] exp_wl;
    logic [13:0] exp_rl;
    logic        exp_empty;
    logic        exp_full;
    logic        exp_aempty;
    logic [15:0] exp_data;
  } vec_t;

  localparam int NumVec = 18;
  vec_t vecs [NumVec];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] fill_byte(input int j);
    logic [7:0] b;
    b = 8'hFF - 8'(j);
    return b;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, " rd_empty"}, 32'(bus.rd_empty), 32'd1);
    chk({tag, " almost_empty"}, 32'(bus.almost_empty), 32'd1);
    chk({tag, " wr_full"}, 32'(bus.wr_full), 32'd0);
    chk({tag, " almost_full"}, 32'(bus.almost_full), 32'd0);
    chk({tag, " wr_level"}, 32'(bus.wr_water_level), 32'd0);
    chk({tag, " rd_level"}, 32'(bus.rd_water_level), 32'd0);
    chk({tag, " rd_data"}, 32'(bus.rd_data), 32'd0);
  endtask

  initial begin
    logic [15:0] exp_word;

    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.wr_data = 8'h00;

    // Odd-byte, read-while-empty and simultaneous read/write vectors.
    vecs[0] = '{1'b1, 8'h11, 1'b0, 15'd1, 14'd0, 1'b1, 1'b0, 1'b1, 16'h0001};
    vecs[1] = '{1'b1, 8'h22, 1'b0, 15'd2, 14'd1, 1'b0, 1'b0, 1'b1, 16'h0001};
    vecs[2] = '{1'b1, 8'h33, 1'b0, 15'd3, 14'd1, 1'b0, 1'b0, 1'b1, 16'h0001};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 15'd1, 14'd0, 1'b1, 1'b0, 1'b1, 16'h2211};
    vecs[4] = '{1'b1, 8'h44, 1'b0, 15'd2, 14'd1, 1'b0, 1'b0, 1'b1, 16'h2211};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 15'd0, 14'd0, 1'b1, 1'b0, 1'b1, 16'h4433};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 15'd0, 14'd0, 1'b1, 1'b0, 1'b1, 16'h4433};
    vecs[7] = '{1'b1, 8'h50, 1'b1, 15'd1, 14'd0, 1'b1, 1'b0, 1'b1, 16'h4433};
    for (int i = 0; i < 9; i++) begin
      vecs[8+i] = '{1'b1, 8'(8'h51 + i), 1'b0, 15'(2 + i), 14'((2 + i) / 2), 1'b0, 1'b0,
                    1'(((2 + i) / 2) <= 4), 16'h4433};
    end
    vecs[17] = '{1'b1, 8'h5A, 1'b1, 15'd9, 14'd4, 1'b0, 1'b0, 1'b1, 16'h5150};

    // Reset held 200 ns, released away from a clock edge.
    #203;
    rst_n = 1'b1;
    #1;
    chk_reset_state("reset");

    // Fill with a down-counting byte pattern.
    for (int i = 0; i < 16384; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = fill_byte(i);
      step();
      chk($sformatf("fill wr_level %0d", i), 32'(bus.wr_water_level), 32'(i + 1));
      chk($sformatf("fill almost_full %0d", i), 32'(bus.almost_full), 32'((i + 1) >= 1020));
    end
    chk("fill wr_full", 32'(bus.wr_full), 32'd1);
    chk("fill rd_level", 32'(bus.rd_water_level), 32'd8192);
    chk("fill rd_empty", 32'(bus.rd_empty), 32'd0);
    chk("fill almost_empty", 32'(bus.almost_empty), 32'd0);

    bus.wr_data = 8'hAA;
    step();
    chk("overflow wr_level", 32'(bus.wr_water_level), 32'd16384);
    chk("overflow wr_full", 32'(bus.wr_full), 32'd1);
    bus.wr_en = 1'b0;

    // Drain all words plus one rejected read.
    for (int k = 0; k < 8192; k++) begin
      bus.rd_en = 1'b1;
      step();
      exp_word = {fill_byte(2 * k + 1), fill_byte(2 * k)};
      chk($sformatf("drain word %0d", k), 32'(bus.rd_data), 32'(exp_word));
      chk($sformatf("drain rd_level %0d", k), 32'(bus.rd_water_level), 32'(8191 - k));
      if (k == 0) begin
        chk("drain wr_full drop", 32'(bus.wr_full), 32'd0);
      end
    end
    chk("drain rd_empty", 32'(bus.rd_empty), 32'd1);
    chk("drain almost_full", 32'(bus.almost_full), 32'd0);
    step();
    chk("underflow rd_data", 32'(bus.rd_data), 32'h0001);
    chk("underflow wr_level", 32'(bus.wr_water_level), 32'd0);
    bus.rd_en = 1'b0;

    // Table-driven vectors after both pointers have wrapped.
    for (int v = 0; v < NumVec; v++) begin
      bus.wr_en = vecs[v].wr_en;
      bus.wr_data = vecs[v].wr_data;
      bus.rd_en = vecs[v].rd_en;
      step();
      chk($sformatf("vec%0d wr_level", v), 32'(bus.wr_water_level), 32'(vecs[v].exp_wl));
      chk($sformatf("vec%0d rd_level", v), 32'(bus.rd_water_level), 32'(vecs[v].exp_rl));
      chk($sformatf("vec%0d rd_empty", v), 32'(bus.rd_empty), 32'(vecs[v].exp_empty));
      chk($sformatf("vec%0d wr_full", v), 32'(bus.wr_full), 32'(vecs[v].exp_full));
      chk($sformatf("vec%0d almost_empty", v), 32'(bus.almost_empty), 32'(vecs[v].exp_aempty));
      chk($sformatf("vec%0d rd_data", v), 32'(bus.rd_data), 32'(vecs[v].exp_data));
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;

    // 100 more writes leave an odd count, then an async reset between edges.
    for (int i = 0; i < 100; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(8'h80 + i);
      step();
    end
    chk("pre-reset wr_level", 32'(bus.wr_water_level), 32'd109);
    bus.wr_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("midreset");
    #2;
    rst_n = 1'b1;

    bus.wr_en = 1'b1;
    bus.wr_data = 8'hA1;
    step();
    bus.wr_data = 8'hA2;
    step();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    chk("post-reset rd_data", 32'(bus.rd_data), 32'hA2A1);
    chk("post-reset rd_empty", 32'(bus.rd_empty), 32'd1);
    chk("post-reset wr_level", 32'(bus.wr_water_level), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
